alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_core.sv | 152 +++++++++++++++
 tb/tb_alu_core.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Multi-cycle 16-bit ALU: byte-serial add/subtract and a compare-to-zero operation,
// with a request/ready handshake towards a micro-controller.
module alu_core #(
  parameter int unsigned EXTRA_WAIT = 0
) (
  input  logic        i_SCLK,
  input  logic        i_RESETB,
  input  logic [15:0] i_RX,
  input  logic [15:0] i_RY,
  input  logic [2:0]  i_ALU_ENABLE,
  output logic [15:0] o_RESULT,
  output logic        o_ALU_READY,
  output logic        o_ZERO,
  output logic        o_CARRY,
  output logic        o_OVF,
  output logic        o_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] WAIT_LAST = (EXTRA_WAIT > 0) ? 2'(EXTRA_WAIT - 1) : 2'd0;

  state_t      state;
  logic [15:0] rx;
  logic [15:0] ry;
  logic [2:0]  op;
  logic        carry_lo;
  logic [7:0]  lo_sum;
  logic [1:0]  wait_cnt;

  logic        op_cmp;
  logic        op_add;
  logic        op_sub;
  logic        req_legal;
  logic [15:0] y_eff;
  logic [8:0]  lo_full;
  logic [8:0]  hi_full;
  logic        add_ovf;
  logic        cmp_zero;

  always_comb begin
    op_cmp    = (op == 3'b001);
    op_add    = (op == 3'b010);
    op_sub    = (op == 3'b100);
    req_legal = (i_ALU_ENABLE == 3'b001) || (i_ALU_ENABLE == 3'b010) ||
                (i_ALU_ENABLE == 3'b100);
    // Subtraction is X + ~Y + 1, the +1 entering as the low-byte carry-in.
    y_eff     = op_sub ? ~ry : ry;
    lo_full   = {1'b0, rx[7:0]} + {1'b0, y_eff[7:0]} + {8'd0, op_sub};
    hi_full   = {1'b0, rx[15:8]} + {1'b0, y_eff[15:8]} + {8'd0, carry_lo};
    add_ovf   = (rx[15] == y_eff[15]) && (hi_full[7] != rx[15]);
    cmp_zero  = carry_lo && (rx[15:8] == 8'd0);
  end

  always_ff @(posedge i_SCLK or negedge i_RESETB) begin
    if (!i_RESETB) begin
      state       <= S_IDLE;
      rx          <= '0;
      ry          <= '0;
      op          <= '0;
      carry_lo    <= 1'b0;
      lo_sum      <= '0;
      wait_cnt    <= '0;
      o_RESULT    <= '0;
      o_ALU_READY <= 1'b0;
      o_ZERO      <= 1'b0;
      o_CARRY     <= 1'b0;
      o_OVF       <= 1'b0;
      o_ERR       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_ALU_ENABLE != '0) begin
            rx          <= i_RX;
            ry          <= i_RY;
            op          <= i_ALU_ENABLE;
            o_ALU_READY <= 1'b0;
            if (req_legal) o_ERR <= 1'b0;
            state       <= S_LO;
          end
        end

        S_LO: begin
          if (i_ALU_ENABLE == '0) begin
            state <= S_IDLE;
          end else begin
            // For compare, the carry register holds "low byte is zero".
            carry_lo <= op_cmp ? (rx[7:0] == 8'd0) : lo_full[8];
            lo_sum   <= lo_full[7:0];
            state    <= S_HI;
          end
        end

        S_HI: begin
          if (op_cmp) begin
            o_RESULT <= {15'd0, cmp_zero};
            o_ZERO   <= !cmp_zero;
            o_CARRY  <= 1'b0;
            o_OVF    <= 1'b0;
          end else if (op_add || op_sub) begin
            o_RESULT <= {hi_full[7:0], lo_sum};
            o_ZERO   <= ({hi_full[7:0], lo_sum} == 16'd0);
            o_CARRY  <= op_sub ? !hi_full[8] : hi_full[8];
            o_OVF    <= add_ovf;
          end else begin
            o_RESULT <= '0;
            o_ZERO   <= 1'b1;
            o_CARRY  <= 1'b0;
            o_OVF    <= 1'b0;
            o_ERR    <= 1'b1;
          end
          if (i_ALU_ENABLE == '0) begin
            state <= S_IDLE;
          end else if (EXTRA_WAIT > 0) begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            o_ALU_READY <= 1'b1;
            state       <= S_DONE;
          end
        end

        S_WAIT: begin
          if (i_ALU_ENABLE == '0) begin
            state <= S_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            o_ALU_READY <= 1'b1;
            state       <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        S_DONE: begin
          if (i_ALU_ENABLE == '0) begin
            o_ALU_READY <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed corner cases followed by random
// operations compared against an arithmetic reference model.
module tb_alu_core;

  localparam int unsigned EW = 0;

  logic        clk;
  logic        rst_n;
  logic [15:0] rx;
  logic [15:0] ry;
  logic [2:0]  ena;
  logic [15:0] res;
  logic        ready;
  logic        zero;
  logic        carry;
  logic        ovf;
  logic        err;

  int unsigned total;
  int unsigned bad;

  // {err, ovf, carry, zero, result} expected for the last completed op
  logic [19:0] cur;

  alu_core #(.EXTRA_WAIT(EW)) dut (
    .i_SCLK       (clk),
    .i_RESETB     (rst_n),
    .i_RX         (rx),
    .i_RY         (ry),
    .i_ALU_ENABLE (ena),
    .o_RESULT     (res),
    .o_ALU_READY  (ready),
    .o_ZERO       (zero),
    .o_CARRY      (carry),
    .o_OVF        (ovf),
    .o_ERR        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [2:0] en);
    int          sx;
    int          sy;
    int          t;
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        e;
    sx = $signed(x);
    sy = $signed(y);
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (en)
      3'b001: r = (x == 16'd0) ? 16'd1 : 16'd0;
      3'b010: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[15:0];
        c = s[16];
        t = sx + sy;
        v = (t > 32767) || (t < -32768);
      end
      3'b100: begin
        r = x - y;
        c = (x < y);
        t = sx - sy;
        v = (t > 32767) || (t < -32768);
      end
      default: e = 1'b1;
    endcase
    return {e, v, c, (r == 16'd0), r};
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_res"},   res,   cur[15:0]);
    check({tag, "_zero"},  zero,  cur[16]);
    check({tag, "_carry"}, carry, cur[17]);
    check({tag, "_ovf"},   ovf,   cur[18]);
    check({tag, "_err"},   err,   cur[19]);
  endtask

  // Issue a request and run to ready; optionally scramble inputs while in flight.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [2:0] en,
                       input bit scramble);
    rx = x; ry = y; ena = en;
    @(posedge clk); #1;
    if (scramble) begin
      rx  = 16'($urandom);
      ry  = 16'($urandom);
      ena = 3'($urandom_range(1, 7));
    end
    for (int i = 0; i < 2 + EW; i++) begin
      check("busy", ready, 1'b0);
      @(posedge clk); #1;
    end
    check("ready", ready, 1'b1);
    cur = model(x, y, en);
    check_outputs("op");
  endtask

  task automatic release_req();
    ena = 3'b000;
    @(posedge clk); #1;
    check("drop_ready", ready, 1'b0);
    check_outputs("held");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cur   = '0;
    rst_n = 1'b0;
    rx    = '0;
    ry    = '0;
    ena   = '0;
    #3;
    check("rst_ready", ready, 1'b0);
    check_outputs("rst");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(16'h00FF, 16'h0001, 3'b010, 1'b0);
    check("add_res_const", res, 16'h0100);
    release_req();
    issue(16'h8000, 16'h0001, 3'b100, 1'b0);
    check("sub_ovf_const", ovf, 1'b1);
    release_req();
    issue(16'h0001, 16'h0002, 3'b100, 1'b0);
    check("sub_borrow_const", carry, 1'b1);
    release_req();
    issue(16'h0000, 16'h1234, 3'b001, 1'b0);
    release_req();
    issue(16'h0100, 16'h0000, 3'b001, 1'b0);
    release_req();

    // Enable kept asserted after ready must not start a second operation.
    issue(16'h1234, 16'h1111, 3'b010, 1'b0);
    rx = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("hold_ready", ready, 1'b1);
      check("hold_res", res, 16'h2345);
    end
    release_req();

    issue(16'h0005, 16'h0006, 3'b011, 1'b0);
    release_req();
    issue(16'h0001, 16'h0001, 3'b010, 1'b0);
    check("err_clear_res", res, 16'h0002);
    release_req();

    // Abort while the low byte is being computed: outputs keep prior values.
    rx = 16'h4444; ry = 16'h2222; ena = 3'b100;
    @(posedge clk); #1;
    ena = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_ready", ready, 1'b0);
      check_outputs("abort");
    end

    // Reset pulse while in the high-byte state.
    rx = 16'h7000; ry = 16'h7000; ena = 3'b010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    cur = '0;
    check("midrst_ready", ready, 1'b0);
    check_outputs("midrst");
    ena = 3'b000;
    #1 rst_n = 1'b1;
    issue(16'h0003, 16'h0004, 3'b010, 1'b0);
    release_req();

    for (int n = 0; n < 150; n++) begin
      logic [2:0]  en;
      logic [15:0] x;
      logic [15:0] y;
      en = 3'($urandom_range(1, 7));
      x  = 16'($urandom);
      y  = 16'($urandom);
      case ($urandom_range(0, 3))
        0: x = 16'h0000;
        1: y = x;
        default: ;
      endcase
      issue(x, y, en, 1'b1);
      release_req();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
